// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the prescaled counter family.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  localparam int MAX_WIDTH = 32;

  // Terminal value for a counter of the given width: all ones going up, zero going down.
  function automatic logic [MAX_WIDTH-1:0] counter_limit(input int width, input dir_e dir);
    logic [MAX_WIDTH-1:0] lim;
    lim = '0;
    if (dir == DIR_UP) begin
      if (width >= MAX_WIDTH) begin
        lim = '1;
      end else begin
        lim = (32'd1 << width) - 32'd1;
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enabled-cycle prescaler: raises a combinational tick on the cycle that ends each period.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             WB_CLK,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt;
  logic             period_done;

  // >= so that shrinking prescale below the running count ends the period at once.
  assign period_done = (pcnt >= prescale);
  assign tick        = en & ~clr & period_done;

  always_ff @(posedge WB_CLK or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (period_done) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_prescaled.sv
// Parametrised up/down counter with programmable prescaler, load, wrap/saturate mode
// and registered step / terminal-count pulses.
module counter_prescaled
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             WB_CLK,
  input  logic             reset_n,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             dir,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             tc
);

  logic             tick;
  logic             at_limit;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] out_next;
  logic             step_next;
  logic             tc_next;
  dir_e             dir_sel;
  mode_e            mode_sel;

  assign dir_sel  = dir_e'(dir);
  assign mode_sel = mode_e'(wrap);

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .WB_CLK   (WB_CLK),
    .reset_n  (reset_n),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign limit    = WIDTH'(counter_limit(WIDTH, dir_sel));
  assign at_limit = (out == limit);

  // Load outranks a pending step; the prescaler is cleared by the same strobe.
  always_comb begin
    out_next  = out;
    step_next = 1'b0;
    tc_next   = 1'b0;
    if (load) begin
      out_next = load_val;
    end else if (tick) begin
      step_next = 1'b1;
      if (at_limit) begin
        tc_next = 1'b1;
        if (mode_sel == MODE_WRAP) begin
          out_next = (dir_sel == DIR_UP) ? '0 : '1;
        end
      end else begin
        out_next = (dir_sel == DIR_UP) ? out + 1'b1 : out - 1'b1;
      end
    end
  end

  always_ff @(posedge WB_CLK or negedge reset_n) begin
    if (!reset_n) begin
      out  <= '0;
      step <= 1'b0;
      tc   <= 1'b0;
    end else begin
      out  <= out_next;
      step <= step_next;
      tc   <= tc_next;
    end
  end

endmodule

// File: tb/tb_counter_prescaled.sv
// Directed and randomized checks of counter_prescaled against a cycle-level arithmetic model.
module tb_counter_prescaled;

  localparam int WIDTH = 4;
  localparam int PRE_W = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             WB_CLK;
  logic             reset_n;
  logic             en;
  logic [PRE_W-1:0] prescale;
  logic             dir;
  logic             wrap;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             step;
  logic             tc;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: plain integers advanced once per rising edge.
  int m_out  = 0;
  int m_pcnt = 0;
  int m_step = 0;
  int m_tc   = 0;

  counter_prescaled #(
    .WIDTH (WIDTH),
    .PRE_W (PRE_W)
  ) dut (
    .WB_CLK   (WB_CLK),
    .reset_n  (reset_n),
    .en       (en),
    .prescale (prescale),
    .dir      (dir),
    .wrap     (wrap),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .step     (step),
    .tc       (tc)
  );

  initial WB_CLK = 1'b0;
  always #5 WB_CLK = ~WB_CLK;

  task automatic model_reset();
    m_out  = 0;
    m_pcnt = 0;
    m_step = 0;
    m_tc   = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (load) begin
      m_out  = int'(load_val);
      m_pcnt = 0;
      m_step = 0;
      m_tc   = 0;
    end else if (en) begin
      if (m_pcnt >= int'(prescale)) begin
        m_pcnt = 0;
        m_step = 1;
        if (m_out == (dir ? MAXV : 0)) begin
          m_tc = 1;
          if (wrap) m_out = dir ? 0 : MAXV;
        end else begin
          m_tc  = 0;
          m_out = dir ? (m_out + 1) % (MAXV + 1) : (m_out + MAXV) % (MAXV + 1);
        end
      end else begin
        m_pcnt = m_pcnt + 1;
        m_step = 0;
        m_tc   = 0;
      end
    end else begin
      m_step = 0;
      m_tc   = 0;
    end
  endtask

  task automatic applyStimulus(input logic e, input logic d, input logic w, input logic ld,
                               input int lv, input int ps);
    en       = e;
    dir      = d;
    wrap     = w;
    load     = ld;
    load_val = WIDTH'(lv);
    prescale = PRE_W'(ps);
  endtask

  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] exp_out;
    logic             exp_step;
    logic             exp_tc;
    exp_out  = WIDTH'(m_out);
    exp_step = (m_step != 0);
    exp_tc   = (m_tc != 0);
    tests_run++;
    assert (out === exp_out) else begin
      tests_failed++;
      $error("[TB] FAIL %s out: observed %0d expected %0d", tag, out, exp_out);
    end
    tests_run++;
    assert (step === exp_step) else begin
      tests_failed++;
      $error("[TB] FAIL %s step: observed %b expected %b", tag, step, exp_step);
    end
    tests_run++;
    assert (tc === exp_tc) else begin
      tests_failed++;
      $error("[TB] FAIL %s tc: observed %b expected %b", tag, tc, exp_tc);
    end
  endtask

  task automatic runCycle(input string tag);
    @(posedge WB_CLK);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) runCycle(tag);
  endtask

  initial begin
    // Reset held: outputs zero before and across edges.
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    model_reset();
    #2;
    checkOutput("reset_async");
    runCycles(2, "reset_held");

    // Reset then count: prescale 0, up, wrap; tc once on 15->0.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    reset_n = 1'b1;
    runCycles(18, "count_wrap");

    // Prescaler of 4, with a two-cycle en gap mid-period.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 0, 3);
    runCycle("pre_load");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 3);
    runCycles(9, "prescale4");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    runCycles(2, "en_gap");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 3);
    runCycles(8, "prescale4_after_gap");

    // Saturate down from 2.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2, 0);
    runCycle("sat_down_load");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    runCycles(5, "sat_down");

    // Saturate up at 15.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 15, 0);
    runCycle("sat_up_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    runCycles(4, "sat_up");

    // Load priority over a due step.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    runCycles(2, "pre_priority");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9, 0);
    runCycle("load_priority");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    runCycles(2, "after_load");

    // Async reset with out=7, prescale=5, pcnt=3.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7, 5);
    runCycle("mid_load");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 5);
    runCycles(3, "mid_count");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_mid");
    @(negedge WB_CLK);
    reset_n = 1'b1;
    runCycles(7, "after_reset");

    // Prescale shrink from 10 to 2 with pcnt at 7.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3, 10);
    runCycle("shrink_load");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 10);
    runCycles(7, "shrink_wait");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 2);
    runCycles(4, "shrink");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 15) == 0, int'($urandom_range(0, MAXV)),
                    int'($urandom_range(0, 4)));
      runCycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
